serial_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that succeeds the single-bit half-adder user tile. It accepts two WIDTH-bit operands over a valid/ready handshake and ripples the carry through them CHUNK bits per clock. It presents the sum, carry-out, signed overflow and zero flag over a second valid/ready handshake. It sits between the tile's input pins, through a register wrapper, and the output mux, and trades latency for a small per-cycle adder.

---
 rtl/serial_chunk_adder.sv | 138 +++++++++++++
 tb/tb_serial_chunk_adder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adder/subtractor that ripples the carry CHUNK bits per clock over valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub port and subtract mode; requires WIDTH >= 2, WIDTH % CHUNK == 0.
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_carry_init;
    logic             w_accept;
    logic             w_last;
    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic [WIDTH-1:0] w_sum_next;

    // Subtraction is a + ~b + 1, so only the B operand and the initial carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_eff      = sub ? ~b : b;
    assign w_carry_init = sub ? 1'b1 : cin;
`else
    assign w_b_eff      = b;
    assign w_carry_init = cin;
`endif

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_k == KW'(N - 1));
    assign w_base   = BW'(int'(r_k) * CHUNK);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == IDLE);
        end
    end

    always_comb begin
        {w_chunk_cout, w_chunk_sum} = {1'b0, r_a[w_base +: CHUNK]}
                                    + {1'b0, r_b[w_base +: CHUNK]}
                                    + {{CHUNK{1'b0}}, r_carry};
        w_sum_next                  = r_sum;
        w_sum_next[w_base +: CHUNK] = w_chunk_sum;
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before RUN reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= w_b_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            r_k     <= '0;
            r_carry <= w_carry_init;
        end else if (r_state == RUN) begin
            r_k     <= r_k + KW'(1);
            r_carry <= w_chunk_cout;
            r_sum   <= w_sum_next;
            if (w_last) begin
                // Flags settle only with the last chunk so they stay stable through IDLE and RUN.
                r_k    <= '0;
                r_cout <= w_chunk_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
                r_zero <= (w_sum_next == '0);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: table-driven 8/2 vectors, handshake corner sequences, 16-bit chunk sweep.
`timescale 1ns/1ps
module tb_serial_chunk_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
    logic       s_sub;
`endif

    logic        s_valid;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_cin;
    logic [2:0]  w_ir;
    logic [2:0]  w_ov;
    logic [15:0] w_sum [3];
    logic [2:0]  w_co;
    logic [2:0]  w_of;
    logic [2:0]  w_z;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(w_ir[0]),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(s_sub),
`endif
        .out_valid(w_ov[0]), .out_ready(1'b1),
        .sum(w_sum[0]), .cout(w_co[0]), .ovf(w_of[0]), .zero(w_z[0])
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(w_ir[1]),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(s_sub),
`endif
        .out_valid(w_ov[1]), .out_ready(1'b1),
        .sum(w_sum[1]), .cout(w_co[1]), .ovf(w_of[1]), .zero(w_z[1])
    );

    serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(w_ir[2]),
        .a(s_a), .b(s_b), .cin(s_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(s_sub),
`endif
        .out_valid(w_ov[2]), .out_ready(1'b1),
        .sum(w_sum[2]), .cout(w_co[2]), .ovf(w_of[2]), .zero(w_z[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for in_ready, presents one operation, returns cycles from accept to out_valid.
    task automatic run_op(input vec_t v, output int tlat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", 32'(in_ready), 32'd1);
        a   = v.a;
        b   = v.b;
        cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = v.sub;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tlat = 0;
        while (!out_valid && tlat < 20) begin
            @(negedge clk);
            tlat++;
        end
    endtask

    task automatic sweep_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin, input logic tsub);
        logic [15:0] beff;
        logic [16:0] full;
        logic        eovf;
        int          lat [3];
        logic [15:0] gsum [3];
        logic [2:0]  gco;
        logic [2:0]  gof;
        logic [2:0]  gz;
        int          exp_lat [3];
        int          n;
        exp_lat = '{16, 4, 1};
        beff = tsub ? ~tb_v : tb_v;
        full = {1'b0, ta} + {1'b0, beff} + 17'(tsub ? 1'b1 : tcin);
        eovf = (ta[15] == beff[15]) && (full[15] != ta[15]);
        gco = '0;
        gof = '0;
        gz  = '0;
        n = 0;
        while (w_ir != 3'b111 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sweep_ready", 32'(w_ir), 32'h7);
        s_a   = ta;
        s_b   = tb_v;
        s_cin = tcin;
`ifdef SERIAL_ADDER_SUB_EN
        s_sub = tsub;
`endif
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lat[i]  = -1;
            gsum[i] = '0;
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && w_ov[i]) begin
                    lat[i]  = c;
                    gsum[i] = w_sum[i];
                    gco[i]  = w_co[i];
                    gof[i]  = w_of[i];
                    gz[i]   = w_z[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sweep%0d_lat", i),  32'(lat[i]), 32'(exp_lat[i]));
            check($sformatf("sweep%0d_sum", i),  32'(gsum[i]), 32'(full[15:0]));
            check($sformatf("sweep%0d_cout", i), 32'(gco[i]), 32'(full[16]));
            check($sformatf("sweep%0d_ovf", i),  32'(gof[i]), 32'(eovf));
            check($sformatf("sweep%0d_zero", i), 32'(gz[i]), 32'(full[15:0] == 16'h0));
        end
    endtask

    initial begin
        vec_t vecs [11];
        vec_t v;
        int   tlat;
        int   seen;

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        s_valid   = 1'b0;
        s_a       = '0;
        s_b       = '0;
        s_cin     = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
        s_sub     = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'h00);
        check("rst_zero",      32'(zero),      32'd1);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].sub && !SUB_EN) continue;
            run_op(vecs[i], tlat);
            check($sformatf("vec%0d_lat", i),  32'(tlat),      32'd4);
            check($sformatf("vec%0d_sum", i),  32'(sum),       32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(cout),      32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i),  32'(ovf),       32'(vecs[i].ovf));
            check($sformatf("vec%0d_zero", i), 32'(zero),      32'(vecs[i].zero));
            check($sformatf("vec%0d_busy", i), 32'(in_ready),  32'd0);
        end

        // Backpressure: DONE must hold while a new operand waits at the input.
        @(negedge clk);
        out_ready = 1'b0;
        v = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
        run_op(v, tlat);
        check("bp_lat", 32'(tlat), 32'd4);
        a        = 8'h01;
        b        = 8'h02;
        cin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum",       32'(sum),       32'h46);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_new_op_started", 32'(in_ready), 32'd0);
        tlat = 0;
        while (!out_valid && tlat < 20) begin
            @(negedge clk);
            tlat++;
        end
        check("bp_new_lat", 32'(tlat), 32'd4);
        check("bp_new_sum", 32'(sum),  32'h03);
        out_ready = 1'b1;
        @(negedge clk);

        // Reset while chunk 2 is about to be processed.
        while (!in_ready) @(negedge clk);
        a        = 8'hFF;
        b        = 8'h00;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_pre_sum_low", 32'(sum[3:0]), 32'hF);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sum",       32'(sum),       32'h00);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_zero",      32'(zero),      32'd1);
        check("abort_in_ready",  32'(in_ready),  32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_never_valid", 32'(seen), 32'd0);

        // 16-bit sweep across CHUNK = 1, 4, 16.
        sweep_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        sweep_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        if (SUB_EN) sweep_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sweep_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
